// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding, halt opcode and entry layout for the pc trace buffer
package trace_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, HALTED} state_t;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] ts;
    } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through circular FIFO with optional overwrite-oldest on full
module trace_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr,
    input  logic [W-1:0]             din,
    input  logic                     rd,
    output logic                     valid,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     lost
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic full, pop, push, evict;
    // lost flags a write into a full buffer with no pop to make room
    always_comb begin
        count = wp - rp;
        valid = count != '0;
        full = count == (AW+1)'(DEPTH);
        pop = rd && valid;
        lost = wr && full && !pop;
        evict = lost && OVERWRITE;
        push = wr && (!lost || OVERWRITE);
        dout = valid ? mem[rp[AW-1:0]] : '0;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + (AW+1)'(1);
            if (pop || evict) rp <= rp + (AW+1)'(1);
        end
    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: captures timestamped pc/instr pairs from the core into a FIFO,
// stopping on EBREAK or a pc self-loop, and drains them over a valid/ready port
module pc_trace_buffer import trace_pkg::*; #(
    parameter int XLEN = 32,
    parameter int DEPTH = 16,
    parameter int TS_W = 16,
    parameter logic [31:0] HALT_INSTR = EBREAK_INSTR,
    parameter int STALL_LIMIT = 4,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clear,
    input  logic [XLEN-1:0]          pc,
    input  logic [31:0]              instr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [TS_W-1:0]          rd_time,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted,
    output logic [31:0]              retired
);
    localparam int SW = $clog2(STALL_LIMIT);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [TS_W-1:0] ts;
    } entry_t;
    state_t state;
    logic [TS_W-1:0] ts;
    logic [SW-1:0] stall, stall_nx;
    logic [XLEN-1:0] prev_pc;
    logic cap, detect, halt_nx, lost;
    entry_t head;
    // the capture that leaves IDLE has no previous pc, so it never counts as a stall
    always_comb begin
        cap = en && state != HALTED;
        detect = cap && state == CAPTURE;
        stall_nx = (detect && pc == prev_pc) ? stall + SW'(1) : '0;
        halt_nx = detect && (instr == HALT_INSTR || stall_nx == SW'(STALL_LIMIT - 1));
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            ts <= '0;
            stall <= '0;
            prev_pc <= '0;
            overflow <= 1'b0;
            retired <= '0;
        end else if (clear) begin
            state <= IDLE;
            ts <= '0;
            stall <= '0;
            prev_pc <= '0;
            overflow <= 1'b0;
            retired <= '0;
        end else begin
            if (cap) begin
                state <= halt_nx ? HALTED : CAPTURE;
                ts <= ts + TS_W'(1);
                stall <= stall_nx;
                prev_pc <= pc;
                retired <= retired + {31'd0, ~&retired};
            end
            if (lost) overflow <= 1'b1;
        end
    trace_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_fifo (
        .clk(clk), .reset(reset), .clear(clear),
        .wr(cap), .din(entry_t'{pc, instr, ts}),
        .rd(rd_ready), .valid(rd_valid), .dout(head),
        .count(count), .lost(lost)
    );
    assign rd_pc = head.pc;
    assign rd_instr = head.instr;
    assign rd_time = head.ts;
    assign halted = state == HALTED;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: drop-mode and overwrite-mode instances driven in lockstep against a queue model
module tb_pc_trace_buffer;
    localparam int DEPTH = 4;
    localparam int STALL_LIMIT = 4;
    localparam logic [31:0] HALT = 32'h0010_0073;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] ts;
    } ent_t;

    logic clk = 0, reset = 0, en = 0, clear = 0, rd_ready = 0;
    logic [31:0] pc = 0, instr = 0;
    logic rd_valid [2], overflow [2], halted [2];
    logic [31:0] rd_pc [2], rd_instr [2], retired [2];
    logic [15:0] rd_time [2];
    logic [2:0] count [2];
    int n_pass = 0, n_tot = 0;

    ent_t mq [2][$];
    bit m_run, m_halt, m_ovf;
    int m_stall;
    logic [31:0] m_prev;
    logic [15:0] m_ts;
    longint m_ret;

    always #5 clk = ~clk;

    pc_trace_buffer #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT), .OVERWRITE(1'b0)) u_drop (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pc(pc), .instr(instr),
        .rd_ready(rd_ready), .rd_valid(rd_valid[0]), .rd_pc(rd_pc[0]), .rd_instr(rd_instr[0]),
        .rd_time(rd_time[0]), .count(count[0]), .overflow(overflow[0]), .halted(halted[0]),
        .retired(retired[0]));
    pc_trace_buffer #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT), .OVERWRITE(1'b1)) u_ovw (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pc(pc), .instr(instr),
        .rd_ready(rd_ready), .rd_valid(rd_valid[1]), .rd_pc(rd_pc[1]), .rd_instr(rd_instr[1]),
        .rd_time(rd_time[1]), .count(count[1]), .overflow(overflow[1]), .halted(halted[1]),
        .retired(retired[1]));

    function automatic logic [31:0] rnd_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0000_0013;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) mq[k].delete();
        m_run = 0; m_halt = 0; m_ovf = 0; m_stall = 0; m_prev = 0; m_ts = 0; m_ret = 0;
    endtask

    // apply one cycle of inputs to both the DUTs and the model, then settle past the edge
    task automatic step(input logic e, input logic c, input logic [31:0] p, input logic [31:0] i, input logic r);
        bit full, pop;
        ent_t n;
        en = e; clear = c; pc = p; instr = i; rd_ready = r;
        if (c) model_reset();
        else begin
            full = mq[0].size() == DEPTH;
            pop = r && mq[0].size() > 0;
            for (int k = 0; k < 2; k++) if (pop) void'(mq[k].pop_front());
            if (e && !m_halt) begin
                n.pc = p; n.instr = i; n.ts = m_ts;
                if (full && !pop) begin
                    m_ovf = 1;
                    void'(mq[1].pop_front());
                    mq[1].push_back(n);
                end else for (int k = 0; k < 2; k++) mq[k].push_back(n);
                if (m_run) begin
                    m_stall = (p == m_prev) ? m_stall + 1 : 0;
                    if (i == HALT || m_stall == STALL_LIMIT - 1) m_halt = 1;
                end else m_stall = 0;
                m_run = 1; m_prev = p; m_ts++;
                if (m_ret != 64'hFFFF_FFFF) m_ret++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 0;
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            n_tot++; if (rd_valid[k] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", k, rd_valid[k]); else n_pass++;
            n_tot++; if (count[k] !== 3'd0) $display("FAIL reset_count[%0d]: got %0d want 0", k, count[k]); else n_pass++;
            n_tot++; if (rd_pc[k] !== 32'd0) $display("FAIL reset_pc[%0d]: got %h want 0", k, rd_pc[k]); else n_pass++;
            n_tot++; if ({overflow[k], halted[k]} !== 2'b00) $display("FAIL reset_flags[%0d]: got %b want 00", k, {overflow[k], halted[k]}); else n_pass++;
            n_tot++; if (retired[k] !== 32'd0) $display("FAIL reset_retired[%0d]: got %0d want 0", k, retired[k]); else n_pass++;
        end
        @(negedge clk) reset = 1;
    endtask

    task automatic test_basic();
        step(1, 0, 32'h0, rnd_instr(), 0);
        step(1, 0, 32'h4, rnd_instr(), 0);
        step(1, 0, 32'h8, rnd_instr(), 0);
        for (int k = 0; k < 2; k++) begin
            n_tot++; if (count[k] !== 3'd3) $display("FAIL basic_count[%0d]: got %0d want 3", k, count[k]); else n_pass++;
            n_tot++; if (rd_pc[k] !== 32'h0 || rd_valid[k] !== 1'b1) $display("FAIL basic_head[%0d]: got pc %h v %b want pc 0 v 1", k, rd_pc[k], rd_valid[k]); else n_pass++;
            n_tot++; if (rd_time[k] !== 16'd0) $display("FAIL basic_time[%0d]: got %0d want 0", k, rd_time[k]); else n_pass++;
            n_tot++; if (retired[k] !== 32'd3) $display("FAIL basic_retired[%0d]: got %0d want 3", k, retired[k]); else n_pass++;
            n_tot++; if (halted[k] !== 1'b0) $display("FAIL basic_halted[%0d]: got %b want 0", k, halted[k]); else n_pass++;
        end
    endtask

    task automatic test_halt_instr();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h8; exp_pc[1] = 32'hC; exp_pc[2] = 32'h10;
        step(0, 1, 0, 0, 0);
        step(1, 0, 32'h8, rnd_instr(), 0);
        step(1, 0, 32'hC, rnd_instr(), 0);
        step(1, 0, 32'h10, HALT, 0);
        n_tot++; if (halted[0] !== 1'b1) $display("FAIL halt_flag: got %b want 1", halted[0]); else n_pass++;
        step(1, 0, 32'h14, rnd_instr(), 0);
        step(1, 0, 32'h18, rnd_instr(), 0);
        for (int k = 0; k < 2; k++) begin
            n_tot++; if (count[k] !== 3'd3) $display("FAIL halt_count[%0d]: got %0d want 3", k, count[k]); else n_pass++;
            n_tot++; if (retired[k] !== 32'd3) $display("FAIL halt_retired[%0d]: got %0d want 3", k, retired[k]); else n_pass++;
        end
        for (int j = 0; j < 3; j++) begin
            n_tot++; if (rd_pc[0] !== exp_pc[j]) $display("FAIL halt_drain_pc[%0d]: got %h want %h", j, rd_pc[0], exp_pc[j]); else n_pass++;
            step(0, 0, 0, 0, 1);
        end
        n_tot++; if (rd_valid[0] !== 1'b0 || halted[0] !== 1'b1) $display("FAIL halt_drained: got v %b h %b want v 0 h 1", rd_valid[0], halted[0]); else n_pass++;
    endtask

    task automatic test_stall();
        step(0, 1, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            step(1, 0, 32'h20, rnd_instr(), 0);
            n_tot++; if (halted[0] !== (j == 3)) $display("FAIL stall_halted[%0d]: got %b want %b", j, halted[0], j == 3); else n_pass++;
        end
        step(1, 0, 32'h20, rnd_instr(), 0);
        n_tot++; if (count[0] !== 3'd4 || overflow[0] !== 1'b0) $display("FAIL stall_count: got %0d ovf %b want 4 ovf 0", count[0], overflow[0]); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_tot++; if (rd_pc[0] !== 32'h20 || rd_time[0] !== 16'(j)) $display("FAIL stall_entry[%0d]: got pc %h t %0d want pc 20 t %0d", j, rd_pc[0], rd_time[0], j); else n_pass++;
            step(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_overflow();
        step(0, 1, 0, 0, 0);
        for (int j = 0; j < 6; j++) step(1, 0, 32'h40 + 32'(4 * j), rnd_instr(), 0);
        n_tot++; if (rd_pc[0] !== 32'h40) $display("FAIL ovf_drop_head: got %h want 40", rd_pc[0]); else n_pass++;
        n_tot++; if (rd_pc[1] !== 32'h48) $display("FAIL ovf_overwrite_head: got %h want 48", rd_pc[1]); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_tot++; if (count[k] !== 3'd4) $display("FAIL ovf_count[%0d]: got %0d want 4", k, count[k]); else n_pass++;
            n_tot++; if (overflow[k] !== 1'b1) $display("FAIL ovf_flag[%0d]: got %b want 1", k, overflow[k]); else n_pass++;
            n_tot++; if (retired[k] !== 32'd6) $display("FAIL ovf_retired[%0d]: got %0d want 6", k, retired[k]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0, 0, 0);
        for (int j = 0; j < 4; j++) step(1, 0, 32'h80 + 32'(4 * j), rnd_instr(), 0);
        step(1, 0, 32'h90, rnd_instr(), 1);
        for (int k = 0; k < 2; k++) begin
            n_tot++; if (count[k] !== 3'd4 || overflow[k] !== 1'b0) $display("FAIL b2b_full[%0d]: got %0d ovf %b want 4 ovf 0", k, count[k], overflow[k]); else n_pass++;
        end
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 2; k++) begin
                n_tot++; if (rd_pc[k] !== 32'h84 + 32'(4 * j)) $display("FAIL b2b_order[%0d][%0d]: got %h want %h", k, j, rd_pc[k], 32'h84 + 32'(4 * j)); else n_pass++;
            end
            step(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_reset_clear();
        step(0, 1, 0, 0, 0);
        for (int j = 0; j < 5; j++) step(1, 0, 32'hA0 + 32'(4 * j), rnd_instr(), 0);
        step(1, 1, 32'hC0, rnd_instr(), 0);
        for (int k = 0; k < 2; k++) begin
            n_tot++; if (rd_valid[k] !== 1'b0 || count[k] !== 3'd0) $display("FAIL clear_fifo[%0d]: got v %b c %0d want v 0 c 0", k, rd_valid[k], count[k]); else n_pass++;
            n_tot++; if ({overflow[k], halted[k]} !== 2'b00 || retired[k] !== 32'd0) $display("FAIL clear_state[%0d]: got flags %b ret %0d want 00 ret 0", k, {overflow[k], halted[k]}, retired[k]); else n_pass++;
        end
        for (int j = 0; j < 3; j++) step(1, 0, 32'hB0 + 32'(4 * j), rnd_instr(), 0);
        #2 reset = 0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_tot++; if (rd_valid[k] !== 1'b0 || count[k] !== 3'd0 || rd_pc[k] !== 32'd0) $display("FAIL async_reset[%0d]: got v %b c %0d pc %h want 0", k, rd_valid[k], count[k], rd_pc[k]); else n_pass++;
        end
        @(negedge clk) reset = 1;
        step(1, 0, 32'hD0, rnd_instr(), 0);
        n_tot++; if (rd_time[0] !== 16'd0 || rd_pc[0] !== 32'hD0 || count[0] !== 3'd1) $display("FAIL restart: got t %0d pc %h c %0d want t 0 pc d0 c 1", rd_time[0], rd_pc[0], count[0]); else n_pass++;
    endtask

    task automatic test_random();
        ent_t h;
        bit v;
        step(0, 1, 0, 0, 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            step($urandom_range(3) != 0, $urandom_range(24) == 0, 32'h100 + 32'(4 * $urandom_range(2)),
                 $urandom_range(9) == 0 ? HALT : rnd_instr(), 1'($urandom_range(1)));
            for (int k = 0; k < 2; k++) begin
                v = mq[k].size() != 0;
                if (v) h = mq[k][0];
                else begin h.pc = 0; h.instr = 0; h.ts = 0; end
                n_tot++; if (rd_valid[k] !== v || count[k] !== 3'(mq[k].size())) $display("FAIL rnd_occ[%0d] cyc %0d: got v %b c %0d want v %b c %0d", k, cyc, rd_valid[k], count[k], v, mq[k].size()); else n_pass++;
                n_tot++; if (rd_pc[k] !== h.pc || rd_instr[k] !== h.instr || rd_time[k] !== h.ts) $display("FAIL rnd_head[%0d] cyc %0d: got %h/%h/%0d want %h/%h/%0d", k, cyc, rd_pc[k], rd_instr[k], rd_time[k], h.pc, h.instr, h.ts); else n_pass++;
                n_tot++; if (overflow[k] !== m_ovf || halted[k] !== m_halt) $display("FAIL rnd_flags[%0d] cyc %0d: got ovf %b h %b want ovf %b h %b", k, cyc, overflow[k], halted[k], m_ovf, m_halt); else n_pass++;
                n_tot++; if (retired[k] !== m_ret[31:0]) $display("FAIL rnd_retired[%0d] cyc %0d: got %0d want %0d", k, cyc, retired[k], m_ret); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt_instr();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/pc_trace_buffer.md
Name: pc_trace_buffer

Overview:
Synthesisable on-chip trace capture for the riscv_single_cycle core. It samples the core's pc/instr pair every enabled cycle and stores each pair with a cycle timestamp in a parametrised FIFO. It detects program halt (EBREAK or a PC self-loop) and drains entries over a valid/ready read port. It sits beside the core under the top level and replaces simulation-only $display tracing with hardware that also works on FPGA.

Parameters:
XLEN, 32, width of pc and rd_pc
DEPTH, 16, FIFO entries (power of two, >=2)
TS_W, 16, timestamp counter width
HALT_INSTR, 32'h00100073, instruction word that triggers halt (EBREAK)
STALL_LIMIT, 4, consecutive cycles with unchanged pc that trigger halt (>=2)
OVERWRITE, 0, full-FIFO policy: 0 = drop new entry, 1 = overwrite oldest entry

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
en  in  1  capture enable
clear  in  1  synchronous flush; returns the block to IDLE
pc  in  XLEN  core program counter
instr  in  32  core fetched instruction
rd_ready  in  1  consumer accepts the head entry
rd_valid  out  1  head entry available
rd_pc  out  XLEN  head entry pc
rd_instr  out  32  head entry instruction
rd_time  out  TS_W  head entry timestamp
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky flag: an entry was dropped or overwritten
halted  out  1  halt detected
retired  out  32  number of captured entries, saturating at 32'hFFFFFFFF

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; FIFO empty; rd_valid=0; rd_pc, rd_instr, rd_time=0; count=0; overflow=0; halted=0; retired=0; timestamp=0; stall counter=0.
- The same values apply when clear=1 at a clock edge. clear has priority over every other event.
- States:
  - IDLE: no capture. Go to CAPTURE on the first edge with en=1. The first capture happens on that same edge with timestamp 0.
  - CAPTURE: on each edge with en=1, write {pc, instr, timestamp}, then increment timestamp (wraps modulo 2^TS_W) and retired.
  - CAPTURE with en=0: no write; timestamp holds. The state stays CAPTURE.
  - HALTED: no further writes; timestamp frozen; halted=1. Leave only via reset or clear.
- Halt detection, active only in CAPTURE with en=1:
  - instr==HALT_INSTR: that entry is still written, and halted=1 from the next cycle.
  - Stall: the stall counter increments when pc equals the previously captured pc and resets to 0 otherwise. When it reaches STALL_LIMIT-1, the current entry is written and the state goes to HALTED. This means STALL_LIMIT identical pcs are captured in total.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(DEPTH).
  - First-word-fall-through: rd_* show the head entry whenever rd_valid=1.
  - A pop occurs when rd_valid and rd_ready are both 1 at an edge. The next entry is visible the following cycle.
  - Write latency: an entry captured at edge N is visible on rd_* after edge N when the FIFO was empty (zero extra cycles).
- Full FIFO (count==DEPTH) with a write:
  - If a pop happens on the same edge, the write is accepted in both modes; count is unchanged and overflow is unchanged.
  - OVERWRITE=0, no pop: the new entry is discarded; overflow=1; retired still increments.
  - OVERWRITE=1, no pop: the oldest entry is discarded (read pointer advances) and the new entry is written; overflow=1.
- Empty FIFO with rd_ready=1: no effect.
- Simultaneous write and pop when not full: count is unchanged.
- Assertion of reset in the middle of operation discards all contents immediately, without waiting for a clock edge.

Decomposition:
- Shared package trace_pkg holds:
  - state enum {IDLE, CAPTURE, HALTED}
  - the default HALT_INSTR constant
  - a trace_entry_t struct {pc, instr, time}
- One natural sub-module: trace_fifo, a parametrised width/depth FWFT FIFO with an overwrite option.
- Halt/stall detection and the counters stay in the top-level block.

Test Plan:
- Reset, then en=1 with pcs 0x0, 0x4, 0x8 and non-halt instrs, rd_ready=0 -> count=3, rd_pc=0x0, rd_time=0, retired=3, halted=0.
- instr=32'h00100073 captured at pc 0x10 -> that entry is stored, halted=1 next cycle, later pcs are ignored, and count stays frozen.
- pc held at 0x20 for 4 cycles with STALL_LIMIT=4 -> exactly 4 entries at 0x20 with timestamps t..t+3, then halted=1.
- DEPTH=4, OVERWRITE=0, 6 captures with no reads -> count=4, rd_pc is the 1st pc, overflow=1, retired=6. Repeat with OVERWRITE=1 -> rd_pc is the 3rd pc.
- FIFO full, simultaneous capture and pop -> count stays 4, overflow stays 0, and the order is preserved on drain.
- reset driven low mid-capture with 3 entries, or clear pulsed -> rd_valid=0, count=0, overflow=0, halted=0 immediately (reset) or next edge (clear). Re-enabling restarts timestamps at 0.
